// File: rtl/logic_op_pkg.sv
// logic_op_pkg: opcode encoding and reference bitwise op
// shared by the logic unit stream front-end and its users.
package logic_op_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND = 2'd0;
  localparam op_t OP_OR  = 2'd1;
  localparam op_t OP_NOR = 2'd2;
  localparam op_t OP_NOT = 2'd3;

  localparam int unsigned MAX_W = 64;

  // Callers truncate to their own width; upper bits are junk for NOR/NOT.
  function automatic logic [MAX_W-1:0] logic_op_f(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input op_t              op
  );
    logic [MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      default: r = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: combinational N_BIT-wide AND/OR/NOR/NOT
// selected by a runtime opcode.
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int unsigned N_BIT = 8
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  op_t              op,
  output logic [N_BIT-1:0] res
);

  // Pure bitwise select; b is unused for NOT.
  always_comb begin
    res = '0;
    unique case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOR: res = ~(a | b);
      OP_NOT: res = ~a;
    endcase
  end

endmodule

// File: rtl/logic_op_stream.sv
// logic_op_stream: FIFO-buffered valid/ready front-end issuing
// one opcode-tagged transaction per cycle into logic_op_core.
module logic_op_stream
  import logic_op_pkg::*;
#(
  parameter int unsigned N_BIT = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_BIT-1:0]       in_a,
  input  logic [N_BIT-1:0]       in_b,
  input  op_t                    in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_BIT-1:0]       out_res,
  output op_t                    out_op,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       res_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [N_BIT-1:0] a_mem_q  [DEPTH];
  logic [N_BIT-1:0] b_mem_q  [DEPTH];
  op_t              op_mem_q [DEPTH];

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ov_q, ov_d;
  logic [N_BIT-1:0] res_q, res_d;
  op_t              opo_q, opo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             push;
  logic             pop;
  logic             fire;
  logic [N_BIT-1:0] core_res;

  assign in_ready = (level_q != FULL);
  assign push     = in_valid & in_ready;
  assign fire     = ov_q & out_ready;
  assign pop      = (level_q != '0) & (~ov_q | out_ready);

  logic_op_core #(
    .N_BIT(N_BIT)
  ) u_core (
    .a  (a_mem_q[rd_q]),
    .b  (b_mem_q[rd_q]),
    .op (op_mem_q[rd_q]),
    .res(core_res)
  );

  // Next-state for pointers, level, output register and counter.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
    ov_d    = ov_q;
    res_d   = res_q;
    opo_d   = opo_q;
    cnt_d   = cnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop) begin
      rd_d  = rd_q + AW'(1);
      res_d = core_res;
      opo_d = op_mem_q[rd_q];
      ov_d  = 1'b1;
    end else if (fire) begin
      ov_d  = 1'b0;
    end
    if (fire) cnt_d = cnt_q + CNT_W'(1);
  end

  // State update; storage is written only on an accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      opo_q   <= OP_AND;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_q[i]  <= '0;
        b_mem_q[i]  <= '0;
        op_mem_q[i] <= OP_AND;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      opo_q   <= opo_d;
      cnt_q   <= cnt_d;
      if (push) begin
        a_mem_q[wr_q]  <= in_a;
        b_mem_q[wr_q]  <= in_b;
        op_mem_q[wr_q] <= in_op;
      end
    end
  end

  assign out_valid  = ov_q;
  assign out_res    = res_q;
  assign out_op     = opo_q;
  assign fifo_level = level_q;
  assign res_count  = cnt_q;

endmodule

// File: tb/tb_logic_op_stream.sv
// tb_logic_op_stream: directed + random bench with a queue-based
// cycle model of the stream and a directed result scoreboard.
module tb_logic_op_stream;
  import logic_op_pkg::*;

  localparam int NB = 8;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_a;
  logic [NB-1:0] in_b;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_res;
  logic [1:0]    out_op;
  logic [2:0]    fifo_level;
  logic [CW-1:0] res_count;

  logic_op_stream #(
    .N_BIT(NB),
    .DEPTH(D),
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_op    (out_op),
    .fifo_level(fifo_level),
    .res_count (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } txn_t;

  txn_t       fq[$];
  bit         m_ov;
  logic [7:0] m_res;
  logic [1:0] m_op;
  logic [3:0] m_cnt;
  logic [7:0] dq[$];
  bit         m_acc, m_fire, m_pop;
  txn_t       m_t;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  function automatic logic [7:0] ref_op(
    logic [7:0] a, logic [7:0] b, logic [1:0] op
  );
    if (op == 2'd0) return a & b;
    else if (op == 2'd1) return a | b;
    else if (op == 2'd2) return 8'hFF - (a | b);
    else return 8'hFF ^ a;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO queue plus one output slot, advanced per edge.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      m_ov  = 0;
      m_res = '0;
      m_op  = '0;
      m_cnt = '0;
    end else begin
      m_acc  = in_valid && (fq.size() < D);
      m_fire = m_ov && out_ready;
      m_pop  = (fq.size() > 0) && (!m_ov || out_ready);
      if (m_pop) begin
        m_t   = fq.pop_front();
        m_res = ref_op(m_t.a, m_t.b, m_t.op);
        m_op  = m_t.op;
        m_ov  = 1;
      end else if (m_fire) begin
        m_ov  = 0;
      end
      if (m_acc) fq.push_back('{in_a, in_b, in_op});
      if (m_fire) m_cnt = m_cnt + 4'd1;
    end
  end

  // Compare every DUT output to the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, m_ov);
      check("in_ready", in_ready, fq.size() < D);
      check("fifo_level", fifo_level, fq.size());
      check("res_count", res_count, m_cnt);
      check("out_res", out_res, m_res);
      check("out_op", out_op, m_op);
      if (out_valid && out_ready && dq.size() > 0)
        check("dir_res", out_res, dq.pop_front());
    end
  end

  task automatic send(
    logic [7:0] a, logic [7:0] b, logic [1:0] op, logic [7:0] exp
  );
    bit got;
    got      = 0;
    in_valid = 1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    dq.push_back(exp);
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    in_op    = 2'($urandom);
    if (!got) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    in_valid  = 0;
    out_ready = 1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst      = 1;
    @(posedge clk);
    #1;
    rst = 0;
    dq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] ro;
    rst       = 1;
    in_valid  = 0;
    out_ready = 0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 0;
    chk_en = 1;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_res_count", res_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_res", out_res, 0);
    @(posedge clk);
    #1;

    out_ready = 1;
    send(8'h0F, 8'h03, 2'd0, 8'h03);
    send(8'h0F, 8'h03, 2'd1, 8'h0F);
    send(8'h0F, 8'h03, 2'd2, 8'hF0);
    send(8'h0F, 8'h03, 2'd3, 8'hF0);
    drain();
    check("basic_count", res_count, 4);

    send(8'hAA, 8'h55, 2'd1, 8'hFF);
    send(8'hAA, 8'h55, 2'd2, 8'h00);
    send(8'hA0, 8'h00, 2'd3, 8'h5F);
    drain();
    check("compl_count", res_count, 7);

    out_ready = 0;
    send(8'h3C, 8'h0F, 2'd0, 8'h0C);
    send(8'h3C, 8'h0F, 2'd1, 8'h3F);
    send(8'h3C, 8'h0F, 2'd2, 8'hC0);
    send(8'h3C, 8'h0F, 2'd3, 8'hC3);
    send(8'hFF, 8'h00, 2'd0, 8'h00);
    in_valid = 1;
    in_a     = 8'h12;
    in_b     = 8'h34;
    in_op    = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    check("full_level", fifo_level, 4);
    check("full_ready", in_ready, 0);
    check("hold_valid", out_valid, 1);
    check("hold_res", out_res, 8'h0C);
    out_ready = 1;
    send(8'h12, 8'h34, 2'd1, 8'h36);
    drain();
    check("bp_count", res_count, 13);

    out_ready = 0;
    send(8'h01, 8'h02, 2'd1, 8'h03);
    send(8'hF0, 8'h0F, 2'd0, 8'h00);
    send(8'h55, 8'h00, 2'd3, 8'hAA);
    check("pp_level_start", fifo_level, 2);
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      ra = 8'(i * 37 + 5);
      rb = 8'(i * 91 + 3);
      ro = 2'(i);
      send(ra, rb, ro, ref_op(ra, rb, ro));
    end
    check("pp_level_end", fifo_level, 2);
    drain();

    out_ready = 0;
    for (int i = 0; i < 4; i++) send(8'(i), 8'hFF, 2'd0, 8'(i));
    @(negedge clk);
    check("mid_level", fifo_level, 3);
    check("mid_valid", out_valid, 1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_level", fifo_level, 0);
    check("post_rst_count", res_count, 0);
    @(posedge clk);
    #1;
    out_ready = 1;
    send(8'h81, 8'hAA, 2'd0, 8'h80);
    drain();
    check("post_rst_one", res_count, 1);

    do_reset();
    out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 2'($urandom);
      send(ra, rb, ro, ref_op(ra, rb, ro));
    end
    drain();
    check("cnt_wrap", res_count, 1);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();
    check("rand_empty", fifo_level, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
